// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one sd_cmd engine between NREQ requesters.
// Owns chip select, the per-command timeout and the CS-high gap between commands.
module sd_cmd_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_cmd,
  input  logic [32*NREQ-1:0]   req_args,
  input  logic [8*NREQ-1:0]    req_crc,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_flags,
  output logic [31:0]          rsp_data,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [7:0]           cmd_number,
  output logic [31:0]          cmd_args,
  output logic [7:0]           cmd_crc,
  output logic                 cmd_start,
  input  logic                 cmd_done,
  input  logic [7:0]           response_flags,
  input  logic [31:0]          data_transmission,
  output logic                 CS
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, BUSY, COMPLETE, GAP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, owner, win;
  logic            any_vld;
  logic [TW-1:0]   tmo_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            tmo_hit, gap_end;
  logic [7:0]      sel_cmd, sel_crc;
  logic [31:0]     sel_args;

  // Search upward from rr_ptr+1: first the indices above the pointer, then wrap to the lowest.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] vld, input logic [PW-1:0] ptr);
    logic [PW-1:0] w;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && vld[i] && (i > int'(ptr))) begin
        w     = PW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && vld[i]) begin
        w     = PW'(i);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    win      = rr_pick(req_valid, rr_ptr);
    any_vld  = |req_valid;
    sel_cmd  = '0;
    sel_args = '0;
    sel_crc  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_cmd  = req_cmd[8*i +: 8];
        sel_args = req_args[32*i +: 32];
        sel_crc  = req_crc[8*i +: 8];
      end
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign gap_end = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    cmd_start = 1'b0;
    CS        = 1'b1;
    case (state)
      IDLE: begin
        if (any_vld) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (win == PW'(i));
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        CS        = 1'b0;
        cmd_start = !cmd_done;
        if (cmd_done || tmo_hit) state_nxt = COMPLETE;
      end
      COMPLETE: begin
        for (int i = 0; i < NREQ; i++) rsp_valid[i] = (owner == PW'(i));
        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= PW'(NREQ - 1);
      owner       <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      cmd_number  <= '0;
      cmd_args    <= '0;
      cmd_crc     <= '0;
      rsp_flags   <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_vld) begin
            cmd_number <= sel_cmd;
            cmd_args   <= sel_args;
            cmd_crc    <= sel_crc;
            owner      <= win;
            rr_ptr     <= win;
            tmo_cnt    <= '0;
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          // A completion arriving on the last timeout cycle is still a real response.
          if (cmd_done) begin
            rsp_flags   <= response_flags;
            rsp_data    <= data_transmission;
            rsp_timeout <= 1'b0;
          end else if (tmo_hit) begin
            rsp_flags   <= 8'hFF;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
          end
        end
        COMPLETE: gap_cnt <= '0;
        GAP:      gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- Shares the single sd_cmd SPI command engine between NREQ requesters, e.g. the init sequencer and a block-read controller.
- Arbitrates round-robin, presents the winner's command/args/CRC to sd_cmd, and drives CS.
- Returns response flags and 32-bit data to the owning requester, with a timeout.
- Enforces an idle gap with CS high between commands, giving the card the required ≥8 clocks.

Parameters:
- NREQ, 2, number of requesters (≥2).
- TIMEOUT_CYCLES, 65535, maximum cycles in BUSY before the command is abandoned.
- GAP_CYCLES, 8, CS-high idle cycles after each command.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- req_valid  in  NREQ  requester i has a command pending.
- req_cmd  in  8*NREQ  command byte per requester (0x40|index), slice [8i+7:8i].
- req_args  in  32*NREQ  argument per requester.
- req_crc  in  8*NREQ  CRC byte per requester.
- req_ready  out  NREQ  one-hot; transfer when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-hot, one-cycle pulse to the owner on completion.
- rsp_flags  out  8  R1 flags of the last completed command.
- rsp_data  out  32  trailing data of the last completed command.
- rsp_timeout  out  1  qualifies rsp_valid: last command timed out.
- busy  out  1  state != IDLE.
- cmd_number  out  8  to sd_cmd.
- cmd_args  out  32  to sd_cmd.
- cmd_crc  out  8  to sd_cmd.
- cmd_start  out  1  to sd_cmd, level request.
- cmd_done  in  1  from sd_cmd.
- response_flags  in  8  from sd_cmd.
- data_transmission  in  32  from sd_cmd.
- CS  out  1  SD chip select, active low.

Behaviour:
Reset (reset_n=0 at posedge):
- state=IDLE; rr_ptr=NREQ-1, so requester 0 wins first.
- CS=1; cmd_start=0; req_ready=0; rsp_valid=0; rsp_timeout=0.
- rsp_flags=0x00; rsp_data=0; cmd_number/args/crc=0; timeout and gap counters=0.
- Reset mid-command abandons the command: no rsp_valid, CS=1 the next cycle.

IDLE:
- Winner = first i with req_valid[i], searching from rr_ptr+1 upward with wrap.
- req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
- At that edge: latch winner's cmd/args/crc into cmd_* registers, set owner=winner, rr_ptr=winner, clear timeout counter, go to BUSY.
- No req_valid: stay in IDLE.

BUSY:
- CS=0; cmd_start = !cmd_done; cmd_* hold the latched values.
- Timeout counter increments each cycle.
- cmd_done=1: capture response_flags→rsp_flags, data_transmission→rsp_data, rsp_timeout←0; go to COMPLETE.
- Else if counter == TIMEOUT_CYCLES-1: rsp_flags←0xFF, rsp_data←0, rsp_timeout←1; go to COMPLETE.
- cmd_done in the same cycle as timeout expiry: cmd_done wins.

COMPLETE (1 cycle):
- rsp_valid[owner]=1; CS=1; cmd_start=0; gap counter cleared; go to GAP.

GAP:
- CS=1; count GAP_CYCLES cycles, then go to IDLE.
- GAP_CYCLES=0 goes directly to IDLE.
- req_ready=0 throughout.

Persistence and ignored inputs:
- rsp_flags, rsp_data and rsp_timeout stay stable until the next COMPLETE.
- cmd_done outside BUSY is ignored.
- Changes to req_* after acceptance are ignored.
- A requester dropping req_valid before grant is never granted.

Timing:
- Accept at cycle T; cmd_start=1 and CS=0 from T+1.
- cmd_done seen at cycle D gives rsp_valid at D+1.
- Earliest next accept is D+2+GAP_CYCLES.

Fairness:
- With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.

Test Plan:
- Single request: req0 cmd=0x40, args=0, crc=0x95; model returns done after 20 cycles with flags=0x01 -> req_ready[0] for 1 cycle; CS low exactly from T+1 to done; rsp_valid=01 with rsp_flags=0x01, rsp_timeout=0; CS high ≥8 cycles; busy low after.
- Round-robin: req0 and req1 held valid continuously for 4 commands -> grant order 0,1,0,1; each cmd_number matches the granted requester (0x48 vs 0x51).
- Timeout: TIMEOUT_CYCLES=100, model never asserts done -> rsp_valid at cycle T+101; rsp_flags=0xFF, rsp_data=0, rsp_timeout=1; next accept allowed after the gap.
- Done vs. timeout collision: cmd_done coincides with the last timeout cycle, flags=0x00, data=0x000001AA -> rsp_timeout=0, rsp_flags=0x00, rsp_data=0x000001AA.
- Reset mid-BUSY: reset_n low for 1 cycle during BUSY -> next cycle CS=1, cmd_start=0, no rsp_valid; the first grant afterwards goes to req0 even if req1 was last served.
- Stability: req_args changes during BUSY and a stray cmd_done pulse arrives during GAP -> cmd_args unchanged; no extra rsp_valid; state unaffected.
